// File: rtl/simple_processor_pkg.sv
// Shared types and default widths for the simple_processor memory subsystem.
// Provides the bus widths reused as defaults and the arbiter's state/grant
// enums so the arbiter, its interface and the bench agree on encodings.
package simple_processor_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_e;

    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } arb_grant_e;

endpackage

// File: rtl/simple_mem_arbiter_if.sv
// Bus bundle for simple_mem_arbiter: instruction port (imem_*), data port
// (dmem_*) and the shared downstream memory port (mem_*). Signal suffixes are
// from the arbiter's point of view.
//   slave  : arbiter view (takes requests, drives acks and downstream request)
//   master : environment view (processor ports + memory model)
interface simple_mem_arbiter_if
    import simple_processor_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH
);
    logic                      imem_req_i;
    logic [MEM_ADDR_WIDTH-1:0] imem_addr_i;
    logic [MEM_DATA_WIDTH-1:0] imem_rdata_o;
    logic                      imem_ack_o;

    logic                      dmem_req_i;
    logic                      dmem_we_i;
    logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i;
    logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i;
    logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o;
    logic                      dmem_ack_o;

    logic                      mem_req_o;
    logic                      mem_we_o;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata_o;
    logic [MEM_DATA_WIDTH-1:0] mem_rdata_i;
    logic                      mem_ack_i;

    modport slave (
        input  imem_req_i, imem_addr_i,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output imem_rdata_o, imem_ack_o, dmem_rdata_o, dmem_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output imem_req_i, imem_addr_i,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  imem_rdata_o, imem_ack_o, dmem_rdata_o, dmem_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/simple_mem_arbiter.sv
// simple_mem_arbiter: shares one downstream memory port between the
// instruction and data ports. One transaction in flight at a time; every
// output is a flop.
// Ports:
//   clk_i   - clock, rising edge
//   arst_ni - synchronous active-low reset
//   bus     - simple_mem_arbiter_if.slave (imem_*, dmem_*, mem_* signals)
// Parameters:
//   MEM_ADDR_WIDTH / MEM_DATA_WIDTH - bus widths
//   ROUND_ROBIN - 1: alternate on contention, 0: data port always wins
module simple_mem_arbiter
    import simple_processor_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter bit ROUND_ROBIN    = 1'b1
) (
    input logic                 clk_i,
    input logic                 arst_ni,
    simple_mem_arbiter_if.slave bus
);

    arb_state_e                state_q, state_d;
    arb_grant_e                last_q, last_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [MEM_DATA_WIDTH-1:0] imem_rdata_q, imem_rdata_d;
    logic [MEM_DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;
    logic                      imem_ack_q, imem_ack_d;
    logic                      dmem_ack_q, dmem_ack_d;

    logic imem_elig, dmem_elig, pick_data;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_ack_d   = 1'b0;
        dmem_ack_d   = 1'b0;

        // A port whose ack is high this cycle may still have req asserted from
        // the finished transaction; masking it avoids a spurious re-grant.
        imem_elig = bus.imem_req_i && !imem_ack_q;
        dmem_elig = bus.dmem_req_i && !dmem_ack_q;
        if (ROUND_ROBIN)
            pick_data = dmem_elig && (!imem_elig || last_q == GNT_INSTR);
        else
            pick_data = dmem_elig;

        case (state_q)
            IDLE: begin
                if (imem_elig || dmem_elig) begin
                    mem_req_d = 1'b1;
                    if (pick_data) begin
                        state_d     = BUSY_D;
                        last_d      = GNT_DATA;
                        mem_we_d    = bus.dmem_we_i;
                        mem_addr_d  = bus.dmem_addr_i;
                        mem_wdata_d = bus.dmem_wdata_i;
                    end else begin
                        state_d     = BUSY_I;
                        last_d      = GNT_INSTR;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.imem_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY_I: begin
                if (bus.mem_ack_i) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    imem_rdata_d = bus.mem_rdata_i;
                    imem_ack_d   = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack_i) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    dmem_rdata_d = bus.mem_rdata_i;
                    dmem_ack_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q      <= IDLE;
            last_q       <= GNT_DATA;  // instruction port wins first contention (boot fetch)
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_ack_q   <= 1'b0;
            dmem_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            imem_ack_q   <= imem_ack_d;
            dmem_ack_q   <= dmem_ack_d;
        end
    end

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.imem_rdata_o = imem_rdata_q;
    assign bus.imem_ack_o   = imem_ack_q;
    assign bus.dmem_rdata_o = dmem_rdata_q;
    assign bus.dmem_ack_o   = dmem_ack_q;

    // A requester must hold req until its ack; the transaction still
    // completes if it does not, but the violation is flagged here.
    a_imem_hold: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (state_q == BUSY_I) |-> bus.imem_req_i)
        else $error("imem_req_i dropped before imem_ack_o");
    a_dmem_hold: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (state_q == BUSY_D) |-> bus.dmem_req_i)
        else $error("dmem_req_i dropped before dmem_ack_o");

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Self-checking bench for simple_mem_arbiter. dut0 uses round-robin and gets
// directed tests plus a randomized run against a transaction-level model;
// dut1 uses fixed priority for the data-first contention case.
module tb_simple_mem_arbiter;
    import simple_processor_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;

    simple_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) b0 ();
    simple_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) b1 ();

    simple_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .ROUND_ROBIN(1'b1))
        dut0 (.clk_i(clk), .arst_ni(rst0_n), .bus(b0.slave));
    simple_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .ROUND_ROBIN(1'b0))
        dut1 (.clk_i(clk), .arst_ni(rst1_n), .bus(b1.slave));

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] i_rd_exp, d_rd_exp;

    // request state driven onto b0 by the random phase and its model
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dwd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5a5a);
    endfunction

    task automatic drive0();
        b0.imem_req_i   = ir;
        b0.imem_addr_i  = ia;
        b0.dmem_req_i   = dr;
        b0.dmem_we_i    = dw;
        b0.dmem_addr_i  = da;
        b0.dmem_wdata_i = dwd;
    endtask

    // Memory side of b0: wait (bounded) for a grant, check the downstream
    // request against the expected winner for lat+1 cycles, then ack once.
    task automatic serve0(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int lat, output logic [DW-1:0] rd);
        int n = 0;
        while (!b0.mem_req_o && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_acks_low_at_grant"}, 32'({b0.imem_ack_o, b0.dmem_ack_o}), 32'd0);
        for (int c = 0; c <= lat; c++) begin
            chk({tag, "_req"},   32'(b0.mem_req_o),   32'd1);
            chk({tag, "_we"},    32'(b0.mem_we_o),    32'(we));
            chk({tag, "_addr"},  32'(b0.mem_addr_o),  32'(addr));
            chk({tag, "_wdata"}, 32'(b0.mem_wdata_o), 32'(wdata));
            if (c < lat) tick();
        end
        rd = we ? 16'($urandom) : mrd(addr);
        if (we) mem[addr] = wdata;
        b0.mem_rdata_i = rd;
        b0.mem_ack_i   = 1'b1;
        tick();
        b0.mem_ack_i   = 1'b0;
        b0.mem_rdata_i = 16'($urandom);
        chk({tag, "_req_drop"}, 32'(b0.mem_req_o), 32'd0);
    endtask

    // Checks the ack cycle: only the winner acks, winner's rdata is the value
    // the memory returned, the other port's rdata is unchanged.
    task automatic ack_chk(input string tag, input bit to_data, input logic [DW-1:0] rd);
        if (to_data) d_rd_exp = rd;
        else         i_rd_exp = rd;
        chk({tag, "_imem_ack"},   32'(b0.imem_ack_o),   32'(!to_data));
        chk({tag, "_dmem_ack"},   32'(b0.dmem_ack_o),   32'(to_data));
        chk({tag, "_imem_rdata"}, 32'(b0.imem_rdata_o), 32'(i_rd_exp));
        chk({tag, "_dmem_rdata"}, 32'(b0.dmem_rdata_o), 32'(d_rd_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        int just, last, win;
        bit ie, de;

        rst0_n = 1'b0;
        rst1_n = 1'b0;
        b0.mem_ack_i = 1'b0; b0.mem_rdata_i = '0;
        b1.mem_ack_i = 1'b0; b1.mem_rdata_i = '0;
        b1.imem_req_i = 1'b0; b1.imem_addr_i = '0;
        b1.dmem_req_i = 1'b0; b1.dmem_we_i = 1'b0; b1.dmem_addr_i = '0; b1.dmem_wdata_i = '0;
        mem[16'h0010] = 16'ha5a5;

        // reset with both ports requesting: outputs must stay zero
        ir = 1'b1; ia = 16'h0010;
        dr = 1'b1; dw = 1'b1; da = 16'h0200; dwd = 16'h1234;
        drive0();
        repeat (3) tick();
        chk("rst_mem_req",    32'(b0.mem_req_o),    32'd0);
        chk("rst_mem_we",     32'(b0.mem_we_o),     32'd0);
        chk("rst_mem_addr",   32'(b0.mem_addr_o),   32'd0);
        chk("rst_mem_wdata",  32'(b0.mem_wdata_o),  32'd0);
        chk("rst_imem_ack",   32'(b0.imem_ack_o),   32'd0);
        chk("rst_dmem_ack",   32'(b0.dmem_ack_o),   32'd0);
        chk("rst_imem_rdata", 32'(b0.imem_rdata_o), 32'd0);
        chk("rst_dmem_rdata", 32'(b0.dmem_rdata_o), 32'd0);
        i_rd_exp = '0;
        d_rd_exp = '0;

        // boot fetch: instruction wins first contention; single read of A5A5
        rst0_n = 1'b1;
        serve0("boot_rd", 1'b0, 16'h0010, 16'h0000, 2, rd);
        ir = 1'b0; drive0();
        ack_chk("boot_rd", 1'b0, rd);
        chk("boot_rd_value", 32'(b0.imem_rdata_o), 32'h0000a5a5);

        // single write from the data port, still pending since reset
        serve0("wr", 1'b1, 16'h0200, 16'h1234, 2, rd);
        dr = 1'b0; drive0();
        ack_chk("wr", 1'b1, rd);
        tick();
        chk("wr_ack_once", 32'(b0.dmem_ack_o), 32'd0);

        // round-robin contention, both held, zero-wait memory: I,D,I,D
        ir = 1'b1; ia = 16'h0020;
        dr = 1'b1; dw = 1'b0; da = 16'h0300; dwd = 16'h7777;
        drive0();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) serve0("rr_i", 1'b0, ia, 16'h0000, 0, rd);
            else            serve0("rr_d", 1'b0, da, dwd, 0, rd);
            ack_chk("rr", k % 2 == 1, rd);
        end
        ir = 1'b0; dr = 1'b0; drive0();

        // reset while BUSY_D abandons the transaction; spurious ack ignored
        tick();
        dr = 1'b1; dw = 1'b1; da = 16'h0400; dwd = 16'hbeef; drive0();
        tick();
        chk("mr_granted", 32'(b0.mem_req_o), 32'd1);
        tick();
        rst0_n = 1'b0;
        tick();
        chk("mr_req_drop", 32'(b0.mem_req_o),  32'd0);
        chk("mr_no_ack",   32'(b0.dmem_ack_o), 32'd0);
        i_rd_exp = '0;
        d_rd_exp = '0;
        rst0_n = 1'b1;
        dr = 1'b0; drive0();
        tick();
        chk("mr_no_ack2", 32'(b0.dmem_ack_o), 32'd0);
        b0.mem_ack_i = 1'b1;
        tick();
        b0.mem_ack_i = 1'b0;
        chk("spur_acks", 32'({b0.imem_ack_o, b0.dmem_ack_o}), 32'd0);
        chk("spur_req",  32'(b0.mem_req_o), 32'd0);
        tick();
        chk("spur_acks2", 32'({b0.imem_ack_o, b0.dmem_ack_o}), 32'd0);
        chk("spur_rdata", 32'({b0.imem_rdata_o, b0.dmem_rdata_o}), 32'd0);

        // random traffic vs transaction model; 0=instr, 1=data, 2=none
        last = 1;
        just = 2;
        for (int t = 0; t < 60; t++) begin
            if (!ir && $urandom_range(1) == 1) begin
                ir = 1'b1; ia = 16'($urandom);
            end
            if (!dr && $urandom_range(1) == 1) begin
                dr = 1'b1; dw = 1'($urandom_range(1));
                da = 16'($urandom); dwd = 16'($urandom);
            end
            if (!ir && !dr) begin
                ir = 1'b1; ia = 16'($urandom);
            end
            drive0();
            // the port acked this cycle cannot win now, only a cycle later
            ie = ir && just != 0;
            de = dr && just != 1;
            if (!ie && !de)     win = just;
            else if (ie && de)  win = (last == 1) ? 0 : 1;
            else                win = de ? 1 : 0;
            last = win;
            if (win == 1) serve0("rnd_d", dw, da, dw ? dwd : dwd, $urandom_range(3), rd);
            else          serve0("rnd_i", 1'b0, ia, 16'h0000, $urandom_range(3), rd);
            if (win == 1) dr = 1'b0;
            else          ir = 1'b0;
            drive0();
            ack_chk("rnd", win == 1, rd);
            just = win;
        end
        ir = 1'b0; dr = 1'b0; drive0();

        // fixed priority (dut1): data first, instruction on the next IDLE cycle
        b1.imem_req_i = 1'b1; b1.imem_addr_i = 16'h0040;
        b1.dmem_req_i = 1'b1; b1.dmem_we_i = 1'b0; b1.dmem_addr_i = 16'h0300;
        rst1_n = 1'b1;
        tick();
        chk("fp_data_first", 32'(b1.mem_addr_o), 32'h0300);
        chk("fp_req",        32'(b1.mem_req_o),  32'd1);
        b1.mem_rdata_i = 16'h0bad; b1.mem_ack_i = 1'b1;
        tick();
        b1.mem_ack_i = 1'b0;
        chk("fp_dack",  32'({b1.imem_ack_o, b1.dmem_ack_o}), 32'd1);
        chk("fp_drd",   32'(b1.dmem_rdata_o), 32'h0bad);
        b1.dmem_req_i = 1'b0;
        tick();
        chk("fp_instr_next", 32'(b1.mem_addr_o), 32'h0040);
        chk("fp_we_instr",   32'(b1.mem_we_o),   32'd0);
        b1.mem_rdata_i = 16'h1ee7; b1.mem_ack_i = 1'b1;
        tick();
        b1.mem_ack_i = 1'b0;
        b1.imem_req_i = 1'b0;
        chk("fp_iack", 32'({b1.imem_ack_o, b1.dmem_ack_o}), 32'd2);
        chk("fp_ird",  32'(b1.imem_rdata_o), 32'h1ee7);
        chk("fp_drd_held", 32'(b1.dmem_rdata_o), 32'h0bad);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/simple_mem_arbiter.md
Name: simple_mem_arbiter

Overview:
Shares one external memory port between the processor's instruction port (imem_*) and data port (dmem_*) for single-port memory systems. Grants one requester at a time, forwards its request downstream, and returns the read data and ack to that requester. Sits between simple_processor and the memory model or bus. All outputs are registered.

Parameters:
MEM_ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, width of all address buses
MEM_DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, width of all data buses
ROUND_ROBIN, 1, 1 = alternate grants on contention; 0 = fixed priority, data port wins

Ports:
clk_i  in  1  single global clock, rising edge
arst_ni  in  1  reset, synchronous, active-low; sampled on clk_i rising edge only
imem_req_i  in  1  instruction request; held with imem_addr_i stable until imem_ack_o
imem_addr_i  in  MEM_ADDR_WIDTH  instruction address
imem_rdata_o  out  MEM_DATA_WIDTH  instruction read data; valid while imem_ack_o=1
imem_ack_o  out  1  one-cycle completion pulse to instruction port
dmem_req_i  in  1  data request; held with we, addr, wdata stable until dmem_ack_o
dmem_we_i  in  1  data write enable
dmem_addr_i  in  MEM_ADDR_WIDTH  data address
dmem_wdata_i  in  MEM_DATA_WIDTH  data write data
dmem_rdata_o  out  MEM_DATA_WIDTH  data read data; valid while dmem_ack_o=1
dmem_ack_o  out  1  one-cycle completion pulse to data port
mem_req_o  out  1  downstream request; held until mem_ack_i
mem_we_o  out  1  downstream write enable (0 for instruction grants)
mem_addr_o  out  MEM_ADDR_WIDTH  downstream address
mem_wdata_o  out  MEM_DATA_WIDTH  downstream write data (0 for instruction grants)
mem_rdata_i  in  MEM_DATA_WIDTH  downstream read data; valid with mem_ack_i
mem_ack_i  in  1  downstream completion; single-cycle pulse

Behaviour:
- Reset (arst_ni=0 at an edge): state=IDLE; all outputs=0; last_grant=DATA, so the instruction port wins the first contention after reset (boot fetch). Reset mid-transaction abandons it: mem_req_o drops on the next edge, and no ack is issued for the abandoned request.
- State machine states: IDLE, BUSY_I, BUSY_D.
- IDLE, choose a winner in this order:
  - Only one eligible requester: grant it.
  - Both eligible, ROUND_ROBIN=1: grant the port that is not last_grant.
  - Both eligible, ROUND_ROBIN=0: grant data.
- Eligibility: req_i=1 AND its ack_o is not high this cycle. This stops a requester whose req is still high during its ack cycle from being re-granted.
- On a grant at edge N:
  - From edge N: mem_req_o=1, and mem_we_o, mem_addr_o and mem_wdata_o are registered copies of the winner's inputs.
  - State becomes BUSY_I or BUSY_D; last_grant is updated.
- BUSY_x, mem_ack_i=1 at edge M:
  - mem_req_o=0 and state=IDLE.
  - x_rdata_o = mem_rdata_i; for writes it is the captured mem_rdata_i, don't-care.
  - x_ack_o=1 for exactly one cycle (M to M+1).
  - The other port's ack and rdata stay unchanged.
- BUSY_x, mem_ack_i=0: hold all downstream outputs. Request inputs are not re-sampled, so changes are ignored.
- mem_ack_i while IDLE (spurious) is ignored; no ack is issued.
- Latency: upstream req seen at edge N, grant N, mem_req_o high after N. If mem_ack_i arrives at edge N+k, x_ack_o is high for cycle N+k to N+k+1. The next grant is no earlier than edge N+k+1, so mem_req_o is low for at least one cycle between transactions.
- rdata_o holds its last value between acks and resets to 0.
- Requester dropping req before its ack is a protocol violation. The transaction still completes and the ack is still issued; a simulation assertion flags the violation.
- Widths: pass-through only; no arithmetic.

Decomposition:
- simple_processor_pkg gains:
  - ADDR_WIDTH and DATA_WIDTH (reused as defaults)
  - typedef enum logic [1:0] arb_state_e {IDLE, BUSY_I, BUSY_D}
  - typedef enum logic {GNT_INSTR, GNT_DATA} arb_grant_e
- No sub-module: the 2-way winner select is a few lines inside the block.

Test Plan:
- Reset sequence: hold arst_ni=0 for 3 edges with both req=1 -> all outputs 0. Release -> instruction granted first, mem_addr_o=imem_addr_i.
- Single read: imem_req_i=1, addr=0x0010; memory acks 2 cycles later with rdata=0xA5A5 -> imem_ack_o pulses 1 cycle with imem_rdata_o=0xA5A5; mem_we_o=0 throughout.
- Single write: dmem we=1, addr=0x0200, wdata=0x1234 -> mem_we_o=1, mem_addr_o=0x0200, mem_wdata_o=0x1234 held until mem_ack_i; dmem_ack_o pulses once.
- Contention with ROUND_ROBIN=1: both req held continuously, zero-wait memory -> grants alternate I,D,I,D over 4 transactions; neither port is granted twice in a row.
- Contention with ROUND_ROBIN=0: both req held -> data completes first; instruction is granted on the next IDLE cycle.
- Reset mid-operation and spurious ack: arst_ni=0 while BUSY_D before mem_ack_i -> mem_req_o=0 next edge and dmem_ack_o never pulses. A later mem_ack_i in IDLE -> no upstream ack.
